game_countdown_timer: RTL and testbench

- Round countdown timer for the math game.
- Consumes the one-cycle 1 ms tick pulse from the millisecond tick generator and accumulates ticks into seconds.
- Counts a loaded time limit down to zero and presents remaining seconds as two BCD digits for the seven-segment display path.
- Flags time-out to the game controller, and gates the tick generator through its enable input so ticks only run while a round is live.

---
 rtl/game_countdown_timer_pkg.sv | 33 +++
 rtl/game_countdown_timer_bin_to_bcd99.sv | 18 +
 rtl/game_countdown_timer.sv | 117 +++++++++++
 tb/tb_game_countdown_timer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the math-game round timer: state encoding, BCD widths
// and the two-digit BCD down-count helper.
package game_countdown_timer_pkg;

    localparam int BCD_W   = 4;
    localparam int MAX_SEC = 99;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // Saturating decrement: 00 stays 00, x0 borrows from the tens digit.
    function automatic bcd2_t bcd_dec(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.ones != '0) begin
            r.ones = v.ones - 1'b1;
        end else if (v.tens != '0) begin
            r.ones = BCD_W'(9);
            r.tens = v.tens - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_countdown_timer_bin_to_bcd99.sv
// Combinational 7-bit binary to two BCD digits, saturating at 99.
module bin_to_bcd99
    import game_countdown_timer_pkg::*;
(
    input  logic [6:0]       bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic [6:0] clamped;

    always_comb begin
        clamped = (bin > 7'(MAX_SEC)) ? 7'(MAX_SEC) : bin;
        tens    = BCD_W'(clamped / 7'd10);
        ones    = BCD_W'(clamped % 7'd10);
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: accumulates 1 ms ticks into seconds, counts a loaded
// limit down in BCD, and flags warn/expiry to the game controller.
module game_countdown_timer
    import game_countdown_timer_pkg::*;
#(
    parameter int MS_PER_SEC  = 1000,
    parameter int DEFAULT_SEC = 60,
    parameter int WARN_SEC    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1ms,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [6:0]       load_sec,
    input  logic             use_default,
    output logic             tick_en,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             warn,
    output logic             expired,
    output logic             expired_pulse
);

    localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);
    localparam logic [6:0]      WARN_V  = 7'(WARN_SEC);
    localparam logic [6:0]      DEF_V   = 7'(DEFAULT_SEC);

    state_e          state, state_nxt;
    logic [MS_W-1:0] ms_cnt, ms_nxt;
    bcd2_t           bcd, bcd_nxt, bcd_dec_v, load_bcd;
    logic            pulse_nxt;
    logic [6:0]      load_bin;
    logic [6:0]      rem_bin;

    assign load_bin = (use_default && load_sec == '0) ? DEF_V : load_sec;

    bin_to_bcd99 u_load_conv (
        .bin  (load_bin),
        .tens (load_bcd.tens),
        .ones (load_bcd.ones)
    );

    assign bcd_dec_v = bcd_dec(bcd);

    always_comb begin
        state_nxt = state;
        ms_nxt    = ms_cnt;
        bcd_nxt   = bcd;
        pulse_nxt = 1'b0;
        if (stop) begin
            state_nxt = ST_IDLE;
            ms_nxt    = '0;
            bcd_nxt   = '0;
        end else if (start) begin
            // Any tick in the start cycle is dropped: ms_cnt restarts from 0.
            ms_nxt  = '0;
            bcd_nxt = load_bcd;
            if (load_bcd == '0) begin
                state_nxt = ST_EXPIRED;
                pulse_nxt = 1'b1;
            end else begin
                state_nxt = ST_RUNNING;
            end
        end else begin
            case (state)
                ST_RUNNING: begin
                    if (pause) begin
                        state_nxt = ST_PAUSED;
                    end else if (tick_1ms) begin
                        if (ms_cnt == MS_LAST) begin
                            ms_nxt  = '0;
                            bcd_nxt = bcd_dec_v;
                            if (bcd_dec_v == '0) begin
                                state_nxt = ST_EXPIRED;
                                pulse_nxt = 1'b1;
                            end
                        end else begin
                            ms_nxt = ms_cnt + 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) state_nxt = ST_RUNNING;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            ms_cnt        <= '0;
            bcd           <= '0;
            tick_en       <= 1'b0;
            expired_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            ms_cnt        <= ms_nxt;
            bcd           <= bcd_nxt;
            tick_en       <= (state_nxt == ST_RUNNING);
            expired_pulse <= pulse_nxt;
        end
    end

    assign rem_bin  = 7'(bcd.tens) * 7'd10 + 7'(bcd.ones);
    assign sec_tens = bcd.tens;
    assign sec_ones = bcd.ones;
    assign running  = (state == ST_RUNNING) || (state == ST_PAUSED);
    assign warn     = running && (rem_bin <= WARN_V);
    assign expired  = (state == ST_EXPIRED);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer: stimulus pushes expected outputs
// from a seconds/milliseconds reference model; a monitor pops and compares.
module tb_game_countdown_timer;

    localparam int MS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1ms = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [6:0] load_sec = '0;
    logic       use_default = 1'b0;
    logic       tick_en, running, warn, expired, expired_pulse;
    logic [3:0] sec_tens, sec_ones;

    game_countdown_timer #(.MS_PER_SEC(MS), .DEFAULT_SEC(60), .WARN_SEC(10)) dut (
        .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .start(start), .stop(stop),
        .pause(pause), .load_sec(load_sec), .use_default(use_default),
        .tick_en(tick_en), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .warn(warn), .expired(expired),
        .expired_pulse(expired_pulse)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       en;
        logic       run;
        logic       wrn;
        logic       exp;
        logic       pls;
    } obs_t;

    obs_t  q[$];
    string qn[$];
    int    n_chk = 0, n_fail = 0;
    string phase = "init";
    bit    rst_lvl = 1'b0, pz = 1'b0;

    // Reference model: remaining seconds and elapsed ms as plain integers.
    int rem = 0, ms = 0;
    bit live = 0, paused = 0, done = 0, pls = 0;

    function automatic obs_t model_out();
        obs_t o;
        o.tens = 4'(rem / 10);
        o.ones = 4'(rem % 10);
        o.en   = live && !paused;
        o.run  = live;
        o.wrn  = live && rem <= 10;
        o.exp  = done;
        o.pls  = pls;
        return o;
    endfunction

    function automatic void model_clear();
        rem = 0; ms = 0; live = 0; paused = 0; done = 0; pls = 0;
    endfunction

    function automatic void model_step(bit r, bit st, bit sp, bit ps, bit tk, int ld, bit ud);
        int lim;
        pls = 0;
        if (r || sp) begin
            model_clear();
        end else if (st) begin
            if (ld == 0 && ud) lim = 60;
            else lim = (ld > 99) ? 99 : ld;
            rem = lim; ms = 0; paused = 0;
            live = (lim != 0); done = (lim == 0); pls = (lim == 0);
        end else if (live && paused) begin
            if (!ps) paused = 0;
        end else if (live) begin
            if (ps) paused = 1;
            else if (tk) begin
                ms++;
                if (ms == MS) begin
                    ms = 0; rem--;
                    if (rem == 0) begin live = 0; done = 1; pls = 1; end
                end
            end
        end
    endfunction

    task automatic cycle(input bit st, input bit sp, input bit tk, input int ld, input bit ud);
        @(negedge clk);
        rst = rst_lvl; start = st; stop = sp; pause = pz; tick_1ms = tk;
        load_sec = 7'(ld); use_default = ud;
        model_step(rst_lvl, st, sp, pz, tk, ld, ud);
        q.push_back(model_out());
        qn.push_back(phase);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string nm);
        obs_t a;
        a = {sec_tens, sec_ones, tick_en, running, warn, expired, expired_pulse};
        n_chk++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h, expected all zero", nm, a);
        end
    endtask

    // Monitor: every clock the DUT presents a new output set.
    obs_t  m_exp, m_act;
    string m_nm;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_exp = q.pop_front();
            m_nm  = qn.pop_front();
            m_act = {sec_tens, sec_ones, tick_en, running, warn, expired, expired_pulse};
            n_chk++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got t=%0d o=%0d en=%b run=%b warn=%b exp=%b pls=%b, expected t=%0d o=%0d en=%b run=%b warn=%b exp=%b pls=%b",
                         m_nm, $time, m_act.tens, m_act.ones, m_act.en, m_act.run, m_act.wrn, m_act.exp, m_act.pls,
                         m_exp.tens, m_exp.ones, m_exp.en, m_exp.run, m_exp.wrn, m_exp.exp, m_exp.pls);
            end
        end
    end

    initial begin
        #2 rst = 1'b1;
        #1 check_zero("reset_state");
        rst_lvl = 1'b1;
        phase = "reset"; idle(2);
        rst_lvl = 1'b0;
        idle(2);

        phase = "basic";   cycle(1, 0, 0, 3, 0); ticks(12); idle(3);
        phase = "borrow";  cycle(1, 0, 0, 10, 0); ticks(4); idle(1);
        phase = "pause";   cycle(1, 0, 0, 5, 0); ticks(2);
        pz = 1; ticks(10);
        pz = 0; ticks(2); idle(1);
        phase = "start_pause"; pz = 1; cycle(1, 0, 1, 7, 0); ticks(3);
        pz = 0; ticks(5);
        phase = "clamp";   cycle(1, 0, 0, 120, 0); idle(2);
        phase = "default"; cycle(1, 0, 0, 0, 1); idle(2);
        phase = "zero";    cycle(1, 0, 0, 0, 0); idle(3);
        phase = "start_stop"; cycle(1, 1, 0, 5, 0); idle(1);
        phase = "start_tick"; cycle(1, 0, 0, 9, 0); ticks(2);
        cycle(1, 0, 1, 9, 0); ticks(3); ticks(1); idle(1);
        phase = "expired_restart"; cycle(1, 0, 0, 1, 0); ticks(4); ticks(3); cycle(1, 0, 0, 2, 0); ticks(2);
        cycle(0, 1, 0, 0, 0); idle(1);

        phase = "async_rst"; cycle(1, 0, 0, 8, 0); ticks(4);
        @(negedge clk); #3;
        rst = 1'b1; rst_lvl = 1'b1;
        #1 check_zero("async_rst_immediate");
        model_clear();
        idle(2);
        rst_lvl = 1'b0;
        phase = "post_rst"; ticks(6);
        cycle(1, 0, 0, 2, 0); ticks(8); idle(1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            int ld;
            if ($urandom_range(29) == 0) pz = ~pz;
            ld = ($urandom_range(1) == 0) ? int'($urandom_range(15)) : int'($urandom_range(127));
            cycle($urandom_range(39) == 0, $urandom_range(299) == 0, $urandom_range(1) == 1,
                  ld, $urandom_range(1) == 1);
        end
        pz = 0;
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
